// File: rtl/bcd_seg_scan.sv
// Multiplexed 4-digit 7-segment driver: holds a packed BCD word and scans it
// round-robin onto active-low segment/anode pins with one dead cycle per slot.

module bcd_seg_dec (
   input  logic [3:0] d,
   input  logic       blank,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h3F;
      if (blank) seg = 7'h7F;
      else begin
         case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
         endcase
      end
   end
endmodule

module bcd_seg_scan #(
   parameter int SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] bcd,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [1:0]  digit_sel,
   output logic        frame
);
   localparam int NUM_DIG = 4;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

   typedef struct packed {
      logic [NUM_DIG-1:0][3:0] dig;
      logic                    lz;
   } hold_t;

   hold_t                   hold;
   logic [CW-1:0]           cnt;
   logic [1:0]              idx;
   logic [NUM_DIG-1:0]      zero;
   logic [NUM_DIG-1:0]      blank;
   logic [NUM_DIG-1:0][6:0] dseg;
   logic                    upz;

   // A digit blanks only when it and every digit above it are zero.
   always_comb begin
      blank = '0;
      upz   = 1'b1;
      for (int i = NUM_DIG - 1; i >= 1; i--) begin
         blank[i] = hold.lz & zero[i] & upz;
         upz      = upz & zero[i];
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_DIG; g++) begin : g_dig
         assign zero[g] = (hold.dig[g] == 4'd0);
         bcd_seg_dec u_dec (
            .d     (hold.dig[g]),
            .blank (blank[g]),
            .seg   (dseg[g])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         hold      <= '0;
         cnt       <= '0;
         idx       <= 2'd0;
         seg       <= 7'h7F;
         an        <= 4'hF;
         digit_sel <= 2'd0;
         frame     <= 1'b0;
      end else begin
         if (load) hold <= '{dig: bcd, lz: blank_lz};
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // cnt == 0 is the anode dead time that prevents ghosting between slots.
         seg       <= (cnt == '0) ? 7'h7F : dseg[idx];
         an        <= (cnt == '0) ? 4'hF : ~(4'b0001 << idx);
         digit_sel <= idx;
         frame     <= (idx == 2'd3) && (cnt == CNT_MAX);
      end
   end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized + directed bench for bcd_seg_scan; two instances (SCAN_DIV 4 and 2)
// compared every cycle against a time-indexed behavioural model.

module tb_bcd_seg_scan;
   logic        clk = 1'b0;
   logic        rst, load, blank_lz;
   logic [15:0] bcd;
   logic [6:0]  seg, seg2;
   logic [3:0]  an, an2;
   logic [1:0]  sel, sel2;
   logic        frame, frame2;

   int          checks = 0;
   int          errors = 0;
   int          t = 0;
   logic [15:0] mh = '0;
   logic        ml = 1'b0;

   always #5 clk = ~clk;

   bcd_seg_scan #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd(bcd), .blank_lz(blank_lz),
      .seg(seg), .an(an), .digit_sel(sel), .frame(frame)
   );

   bcd_seg_scan #(.SCAN_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .load(load), .bcd(bcd), .blank_lz(blank_lz),
      .seg(seg2), .an(an2), .digit_sel(sel2), .frame(frame2)
   );

   function automatic logic [6:0] segcode(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Output visible after an edge, given cycles-since-reset tt and held data.
   function automatic logic [13:0] model(input int sd, input int tt,
                                         input logic [15:0] h, input logic l,
                                         input logic r);
      int         c, i;
      logic [6:0] s;
      logic [3:0] a;
      logic       f;
      if (r) return {7'h7F, 4'hF, 2'd0, 1'b0};
      c = tt % sd;
      i = (tt / sd) % 4;
      if (c == 0) s = 7'h7F;
      else if (l && i > 0 && (h >> (4 * i)) == 16'd0) s = 7'h7F;
      else s = segcode(h[4*i +: 4]);
      a = (c == 0) ? 4'hF : ~(4'b0001 << i);
      f = (i == 3) && (c == sd - 1);
      return {s, a, i[1:0], f};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      logic [13:0] e1, e2;
      e1 = model(4, t, mh, ml, rst);
      e2 = model(2, t, mh, ml, rst);
      if (rst) begin
         t = 0; mh = '0; ml = 1'b0;
      end else begin
         t++;
         if (load) begin mh = bcd; ml = blank_lz; end
      end
      @(posedge clk);
      #1;
      chk("seg",    {9'd0, seg},    {9'd0, e1[13:7]});
      chk("an",     {12'd0, an},    {12'd0, e1[6:3]});
      chk("sel",    {14'd0, sel},   {14'd0, e1[2:1]});
      chk("frame",  {15'd0, frame}, {15'd0, e1[0]});
      chk("seg2",   {9'd0, seg2},   {9'd0, e2[13:7]});
      chk("an2",    {12'd0, an2},   {12'd0, e2[6:3]});
      chk("sel2",   {14'd0, sel2},  {14'd0, e2[2:1]});
      chk("frame2", {15'd0, frame2},{15'd0, e2[0]});
   endtask

   logic [15:0] pats [4] = '{16'h0005, 16'h0000, 16'h0102, 16'hA9F0};

   initial begin
      rst = 1'b1; load = 1'b0; bcd = '0; blank_lz = 1'b0;
      repeat (3) tick();

      // normal scan
      rst = 1'b0; load = 1'b1; bcd = 16'h1234;
      tick();
      load = 1'b0;
      repeat (32) tick();

      // leading-zero blanking and invalid codes
      blank_lz = 1'b1;
      for (int k = 0; k < 4; k++) begin
         load = 1'b1; bcd = pats[k];
         tick();
         load = 1'b0;
         repeat (16) tick();
      end

      // reset mid-scan, during digit 2's lit cycles
      blank_lz = 1'b0; load = 1'b1; bcd = 16'h1234;
      tick();
      load = 1'b0;
      while (!(sel == 2'd2 && an == 4'b1011)) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (20) tick();

      // load coincident with reset is dropped, then a mid-slot load
      rst = 1'b1; load = 1'b1; bcd = 16'h9999;
      tick();
      rst = 1'b0; load = 1'b0;
      repeat (18) tick();
      load = 1'b1;
      tick();
      load = 1'b0;
      repeat (16) tick();

      // randomized traffic
      repeat (800) begin
         rst  = ($urandom_range(0, 79) == 0);
         load = ($urandom_range(0, 5) == 0);
         bcd  = 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            for (int k = 0; k < 4; k++) bcd[4*k +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 2) == 0) bcd[15:8] = 8'h00;
         blank_lz = 1'($urandom);
         tick();
      end
      rst = 1'b0; load = 1'b0;
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
